// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester Avalon bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Wide enough for any supported DATA_W; users slice the low DATA_W/8 bits.
  localparam logic [63:0] BE_ALL = '1;
  localparam int unsigned RD_LAT_MAX = 3;

endpackage

// File: rtl/avalon_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between fetch (bit 0) and data (bit 1).
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  owner_t     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_i && req_d) begin
      gnt = (last_grant == OWN_D) ? 2'b01 : 2'b10;
    end else if (req_i) begin
      gnt = 2'b01;
    end else if (req_d) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon memory bus between instruction fetch and data load/store,
// one transfer at a time, and routes read data back to its owner.
module avalon_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                ireq_ready,
  output logic                irsp_valid,
  output logic [DATA_W-1:0]   irsp_data,
  input  logic                dreq_valid,
  input  logic                dreq_write,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [DATA_W-1:0]   dreq_wdata,
  input  logic [DATA_W/8-1:0] dreq_be,
  output logic                dreq_ready,
  output logic                drsp_valid,
  output logic [DATA_W-1:0]   drsp_data,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] CNT_INIT = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  state_t     state;
  owner_t     last_grant;
  owner_t     owner;
  logic [1:0] cnt;
  logic [1:0] gnt;
  logic       rsp_fire;

  rr_arb2 u_arb (
    .req_i      (ireq_valid),
    .req_d      (dreq_valid),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Handshake: a requester holds valid and its fields until it sees the
  // one-cycle ready pulse; ready fires only in IDLE, in the cycle the request
  // is captured. rsp_valid is a one-cycle pulse with no back-pressure.
  assign ireq_ready = !reset && (state == IDLE) && gnt[0];
  assign dreq_ready = !reset && (state == IDLE) && gnt[1];
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // Zero-latency reads complete at the acceptance edge itself.
  assign rsp_fire = ((state == ISSUE) && read && !waitrequest && (RD_LAT == 0)) ||
                    ((state == WAIT_DATA) && (cnt == 2'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= OWN_D;
      owner      <= OWN_I;
      cnt        <= 2'd0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      irsp_valid <= 1'b0;
      irsp_data  <= '0;
      drsp_valid <= 1'b0;
      drsp_data  <= '0;
    end else begin
      irsp_valid <= rsp_fire && (owner == OWN_I);
      drsp_valid <= rsp_fire && (owner == OWN_D);
      if (rsp_fire && (owner == OWN_I)) irsp_data <= readdata;
      if (rsp_fire && (owner == OWN_D)) drsp_data <= readdata;

      case (state)
        IDLE: begin
          if (gnt[0]) begin
            state      <= ISSUE;
            last_grant <= OWN_I;
            owner      <= OWN_I;
            address    <= ireq_addr;
            read       <= 1'b1;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= BE_ALL[BE_W-1:0];
          end else if (gnt[1]) begin
            state      <= ISSUE;
            last_grant <= OWN_D;
            owner      <= OWN_D;
            address    <= dreq_addr;
            read       <= !dreq_write;
            write      <= dreq_write;
            writedata  <= dreq_wdata;
            byteenable <= dreq_be;
          end
        end
        ISSUE: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            if (write || (RD_LAT == 0)) begin
              state <= IDLE;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (cnt == 2'd0) state <= IDLE;
          else             cnt   <= cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: three instances (RD_LAT 1, 0, 3) with a
// latency-exact slave each, directed scenarios and a randomized reference model.
module tb_avalon_bus_arbiter;
  import bus_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ireq_valid[3], ireq_ready[3], irsp_valid[3];
  logic        dreq_valid[3], dreq_write[3], dreq_ready[3], drsp_valid[3];
  logic        read[3], write[3], waitrequest[3], busy[3], force_en[3];
  logic [31:0] ireq_addr[3], irsp_data[3], dreq_addr[3], dreq_wdata[3], drsp_data[3];
  logic [31:0] address[3], writedata[3], force_val[3];
  logic [3:0]  dreq_be[3], byteenable[3];
  state_t      dbg_state[3];

  int pass_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];
  bit          gseq[$];

  function automatic logic [31:0] slave_word(input int k, input logic [31:0] a);
    return force_en[k] ? force_val[k] : ((a ^ 32'hA5C3_0F1E) + 32'h0101_0101);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [31:0] rd_g;
    logic [31:0] val;
    logic        pend;
    int          cnt_s;

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid[g]), .ireq_addr(ireq_addr[g]), .ireq_ready(ireq_ready[g]),
      .irsp_valid(irsp_valid[g]), .irsp_data(irsp_data[g]),
      .dreq_valid(dreq_valid[g]), .dreq_write(dreq_write[g]), .dreq_addr(dreq_addr[g]),
      .dreq_wdata(dreq_wdata[g]), .dreq_be(dreq_be[g]), .dreq_ready(dreq_ready[g]),
      .drsp_valid(drsp_valid[g]), .drsp_data(drsp_data[g]),
      .address(address[g]), .read(read[g]), .write(write[g]), .writedata(writedata[g]),
      .byteenable(byteenable[g]), .waitrequest(waitrequest[g]), .readdata(rd_g),
      .busy(busy[g]), .dbg_state(dbg_state[g])
    );

    // Slave drives the true word only in the cycle ending at the sampling edge.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        pend  <= 1'b0;
        cnt_s <= 0;
        val   <= '0;
      end else if (read[g] && !waitrequest[g]) begin
        pend  <= 1'b1;
        cnt_s <= 1;
        val   <= slave_word(g, address[g]);
      end else if (pend) begin
        cnt_s <= cnt_s + 1;
        if (cnt_s >= LAT) pend <= 1'b0;
      end
    end

    assign rd_g = (LAT == 0) ?
                  ((read[g] && !waitrequest[g]) ? slave_word(g, address[g]) : ~slave_word(g, address[g])) :
                  ((pend && cnt_s == LAT) ? val : ~val);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ireq_valid[k] = 0; ireq_addr[k] = '0; dreq_valid[k] = 0; dreq_write[k] = 0;
      dreq_addr[k] = '0; dreq_wdata[k] = '0; dreq_be[k] = '0; waitrequest[k] = 0;
      force_en[k] = 0; force_val[k] = '0;
    end
    exp_q.delete();
    gseq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ireq_valid[0] = 1'b1;
    dreq_valid[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if ({ireq_ready[k], dreq_ready[k], irsp_valid[k], drsp_valid[k], read[k], write[k], busy[k]} !== 7'b0)
        $display("FAIL reset_ctl[%0d]: got %b required 0", k,
                 {ireq_ready[k], dreq_ready[k], irsp_valid[k], drsp_valid[k], read[k], write[k], busy[k]});
      else pass_cnt++;
      chk_cnt++;
      if ({address[k], writedata[k], byteenable[k], irsp_data[k], drsp_data[k]} !== 132'b0)
        $display("FAIL reset_data[%0d]: got %h required 0", k,
                 {address[k], writedata[k], byteenable[k], irsp_data[k], drsp_data[k]});
      else pass_cnt++;
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (dbg_state[k] !== IDLE || busy[k] !== 1'b0)
        $display("FAIL reset_state[%0d]: got state %0d busy %b required IDLE/0", k, dbg_state[k], busy[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fetch_first();
    logic [36:0] exp_bus;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        ireq_valid[0] = 1'b1; ireq_addr[0] = 32'hBFC0_0000;
        force_en[0] = 1'b1; force_val[0] = 32'h3C02_FFFF;
      end else begin
        ireq_valid[0] = 1'b0;
      end
      @(negedge clk);
      exp_bus = (c == 1) ? {1'b1, 32'hBFC0_0000, 4'hF} : 37'b0;
      chk_cnt++;
      if (ireq_ready[0] !== (c == 0)) $display("FAIL fetch_ready c%0d: got %b required %b", c, ireq_ready[0], c == 0);
      else pass_cnt++;
      chk_cnt++;
      if ({read[0], address[0], byteenable[0]} !== exp_bus)
        $display("FAIL fetch_bus c%0d: got %h required %h", c, {read[0], address[0], byteenable[0]}, exp_bus);
      else pass_cnt++;
      chk_cnt++;
      if (irsp_valid[0] !== (c == 3)) $display("FAIL fetch_rsp c%0d: got %b required %b", c, irsp_valid[0], c == 3);
      else pass_cnt++;
      chk_cnt++;
      if (busy[0] !== (c == 1 || c == 2)) $display("FAIL fetch_busy c%0d: got %b required %b", c, busy[0], c == 1 || c == 2);
      else pass_cnt++;
      if (c >= 3) begin
        chk_cnt++;
        if (irsp_data[0] !== 32'h3C02_FFFF) $display("FAIL fetch_data c%0d: got %h required 3c02ffff", c, irsp_data[0]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_store_stall();
    logic [69:0] exp_bus;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      dreq_valid[0] = (c == 0); dreq_write[0] = 1'b1; dreq_addr[0] = 32'h10;
      dreq_wdata[0] = 32'hDEAD_BEEF; dreq_be[0] = 4'b0011;
      waitrequest[0] = (c >= 1 && c <= 4);
      @(negedge clk);
      exp_bus = (c >= 1 && c <= 5) ? {1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011} : 70'b0;
      chk_cnt++;
      if (dreq_ready[0] !== (c == 0)) $display("FAIL store_ready c%0d: got %b required %b", c, dreq_ready[0], c == 0);
      else pass_cnt++;
      chk_cnt++;
      if ({read[0], write[0], address[0], writedata[0], byteenable[0]} !== exp_bus)
        $display("FAIL store_bus c%0d: got %h required %h", c,
                 {read[0], write[0], address[0], writedata[0], byteenable[0]}, exp_bus);
      else pass_cnt++;
      chk_cnt++;
      if (drsp_valid[0] !== 1'b0 || busy[0] !== (c >= 1 && c <= 5))
        $display("FAIL store_rsp_busy c%0d: got %b%b required 0%b", c, drsp_valid[0], busy[0], c >= 1 && c <= 5);
      else pass_cnt++;
    end
  endtask

  task automatic test_lat(input int k, input int lat);
    int due;
    do_reset();
    due = lat + 2;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      dreq_valid[k] = (c == 0); dreq_write[k] = 1'b0; dreq_addr[k] = 32'h1000; dreq_be[k] = 4'hF;
      force_en[k] = 1'b1; force_val[k] = 32'hFFFF_0000; waitrequest[k] = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (drsp_valid[k] !== (c == due) || read[k] !== (c == 1))
        $display("FAIL lat%0d_timing c%0d: got rsp %b read %b required %b %b", lat, c, drsp_valid[k], read[k], c == due, c == 1);
      else pass_cnt++;
      if (c >= due) begin
        chk_cnt++;
        if (drsp_data[k] !== 32'hFFFF_0000) $display("FAIL lat%0d_data c%0d: got %h required ffff0000", lat, c, drsp_data[k]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      dreq_valid[0] = (c == 0); dreq_write[0] = 1'b0; dreq_addr[0] = 32'h20; dreq_be[0] = 4'hF;
      waitrequest[0] = 1'b1;
    end
    @(negedge clk);
    chk_cnt++;
    if (read[0] !== 1'b1) $display("FAIL midrst_pre: got read %b required 1", read[0]);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({read[0], write[0], busy[0], address[0]} !== 35'b0)
      $display("FAIL midrst_async: got %h required 0", {read[0], write[0], busy[0], address[0]});
    else pass_cnt++;
    waitrequest[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      ireq_valid[0] = (c == 0); ireq_addr[0] = 32'h40;
      dreq_valid[0] = (c == 0); dreq_addr[0] = 32'h80;
      @(negedge clk);
      if (c == 0) begin
        chk_cnt++;
        if ({ireq_ready[0], dreq_ready[0]} !== 2'b10)
          $display("FAIL midrst_tie: got %b required 10", {ireq_ready[0], dreq_ready[0]});
        else pass_cnt++;
      end
      chk_cnt++;
      if (drsp_valid[0] !== 1'b0 || irsp_valid[0] !== (c == 3))
        $display("FAIL midrst_rsp c%0d: got d%b i%b required d0 i%b", c, drsp_valid[0], irsp_valid[0], c == 3);
      else pass_cnt++;
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      ireq_valid[0] = (c == 0); ireq_addr[0] = 32'h100;
      dreq_valid[0] = (c == 0); dreq_write[0] = 1'b1; dreq_addr[0] = 32'h200;
      dreq_wdata[0] = 32'h1; dreq_be[0] = 4'hF;
      @(negedge clk);
      chk_cnt++;
      if ({dreq_ready[0], write[0], drsp_valid[0]} !== 3'b0 || ireq_ready[0] !== (c == 0))
        $display("FAIL withdraw_c%0d: got dr %b wr %b drsp %b ir %b", c, dreq_ready[0], write[0], drsp_valid[0], ireq_ready[0]);
      else pass_cnt++;
      if (c >= 3) begin
        chk_cnt++;
        if ({busy[0], read[0], address[0]} !== 34'b0)
          $display("FAIL withdraw_idle c%0d: got %h required 0", c, {busy[0], read[0], address[0]});
        else pass_cnt++;
      end
    end
  endtask

  // Reference model: transfer phases tracked as cycle numbers from the rules
  // (grant -> issue until waitrequest low -> idle after write or after RD_LAT+1 for reads).
  task automatic run_model(input int k, input int lat, input int ncyc, input int stall_pct,
                           input int req_pct, input bit keep_valid, input bit d_loads_only);
    bit iv, dv, dwr, w, last, c_wr, c_own, gi, gd, done, drain;
    logic [31:0] ia, da, dwd, c_addr, c_wd, hold_i, hold_d, obs_wd;
    logic [3:0] dbe, c_be;
    logic [69:0] exp_bus, obs_bus;
    state_t exp_st;
    int phase, idle_at, resp_due, t;
    bit resp_own;
    do_reset();
    iv = 0; dv = 0; dwr = 0; last = 1; phase = 0; idle_at = -1; resp_due = -1; resp_own = 0;
    ia = '0; da = '0; dwd = '0; dbe = '0; c_addr = '0; c_wd = '0; c_be = '0; c_wr = 0; c_own = 0;
    hold_i = '0; hold_d = '0; done = 0;
    for (t = 0; t < ncyc + 60 && !done; t++) begin
      @(posedge clk); #1;
      drain = (t >= ncyc);
      if (!iv && !drain && $urandom_range(99) < req_pct) begin
        iv = 1; ia = $urandom;
      end else if (iv && !keep_valid && $urandom_range(99) < 3) iv = 0;
      if (!dv && !drain && $urandom_range(99) < req_pct) begin
        dv = 1; dwr = d_loads_only ? 1'b0 : 1'($urandom_range(1));
        da = d_loads_only ? 32'h1000 : $urandom; dwd = $urandom; dbe = 4'($urandom_range(15));
      end else if (dv && !keep_valid && $urandom_range(99) < 3) dv = 0;
      w = ($urandom_range(99) < stall_pct);
      ireq_valid[k] = iv; ireq_addr[k] = ia;
      dreq_valid[k] = dv; dreq_write[k] = dwr; dreq_addr[k] = da; dreq_wdata[k] = dwd; dreq_be[k] = dbe;
      waitrequest[k] = w;
      @(negedge clk);
      if (phase == 2 && t == idle_at) phase = 0;
      if (resp_due == t) begin
        if (resp_own) hold_d = exp_q.pop_front();
        else          hold_i = exp_q.pop_front();
      end
      gi = (phase == 0) && iv && (!dv || last);
      gd = (phase == 0) && dv && (!iv || !last);
      exp_bus = (phase == 1) ? {!c_wr, c_wr, c_addr, c_wd, c_be} : 70'b0;
      obs_wd = (phase == 1 && !c_wr) ? c_wd : writedata[k];
      obs_bus = {read[k], write[k], address[k], obs_wd, byteenable[k]};
      exp_st = (phase == 0) ? IDLE : ((phase == 1) ? ISSUE : WAIT_DATA);
      chk_cnt++;
      if (obs_bus !== exp_bus) $display("FAIL rnd_bus k%0d t%0d: got %h required %h", k, t, obs_bus, exp_bus);
      else pass_cnt++;
      chk_cnt++;
      if ({ireq_ready[k], dreq_ready[k]} !== {gi, gd})
        $display("FAIL rnd_ready k%0d t%0d: got %b required %b", k, t, {ireq_ready[k], dreq_ready[k]}, {gi, gd});
      else pass_cnt++;
      chk_cnt++;
      if ({irsp_valid[k], drsp_valid[k]} !== {resp_due == t && !resp_own, resp_due == t && resp_own})
        $display("FAIL rnd_rsp k%0d t%0d: got %b required %b", k, t, {irsp_valid[k], drsp_valid[k]},
                 {resp_due == t && !resp_own, resp_due == t && resp_own});
      else pass_cnt++;
      chk_cnt++;
      if ({irsp_data[k], drsp_data[k]} !== {hold_i, hold_d})
        $display("FAIL rnd_data k%0d t%0d: got %h required %h", k, t, {irsp_data[k], drsp_data[k]}, {hold_i, hold_d});
      else pass_cnt++;
      chk_cnt++;
      if (busy[k] !== (phase != 0) || dbg_state[k] !== exp_st)
        $display("FAIL rnd_state k%0d t%0d: got busy %b state %0d required %b %0d", k, t, busy[k], dbg_state[k], phase != 0, exp_st);
      else pass_cnt++;
      if (gi || gd) begin
        c_own = gd; c_wr = gd ? dwr : 1'b0; c_addr = gd ? da : ia;
        c_wd = gd ? dwd : 32'h0; c_be = gd ? dbe : 4'hF;
        last = gd; phase = 1; gseq.push_back(gd);
        if (gd) dv = 0; else iv = 0;
      end else if (phase == 1 && !w) begin
        phase = 2;
        if (c_wr) idle_at = t + 1;
        else begin
          idle_at = t + lat + 1; resp_due = idle_at; resp_own = c_own;
          exp_q.push_back(slave_word(k, c_addr));
        end
      end
      if (drain && phase == 0 && !iv && !dv && exp_q.size() == 0) done = 1;
    end
    chk_cnt++;
    if (!done) $display("FAIL rnd_drain k%0d: got busy at cycle budget end required idle", k);
    else pass_cnt++;
  endtask

  task automatic test_random();
    run_model(0, 1, 300, 40, 50, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_model(0, 1, 60, 0, 100, 1'b1, 1'b1);
    chk_cnt++;
    if (gseq.size() < 10 || gseq[0] !== 1'b0)
      $display("FAIL b2b_count: got %0d grants first %b required >=10 first 0", gseq.size(), gseq[0]);
    else pass_cnt++;
    for (int i = 1; i < gseq.size(); i++) begin
      chk_cnt++;
      if (gseq[i] === gseq[i-1]) $display("FAIL b2b_alt[%0d]: got %b twice required alternation", i, gseq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_lat_random();
    run_model(1, 0, 200, 40, 50, 1'b0, 1'b0);
    run_model(2, 3, 200, 40, 50, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fetch_first();
    test_store_stall();
    test_lat(1, 0);
    test_lat(2, 3);
    test_reset_mid_issue();
    test_withdraw();
    test_random();
    test_back_to_back();
    test_lat_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Shares the CPU's single Avalon-style memory bus between two requesters: instruction fetch (I) and data load/store (D).
- Sequences each transfer through grant, issue, waitrequest stall and fixed read latency, then returns the read data to the requester that owns it.
- Sits between the CPU core front-end and `mips_cpu_bus`'s external memory port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byteenable width = DATA_W/8).
- RD_LAT, 1, cycles from read acceptance (waitrequest low at posedge) to readdata valid; legal range 0..3.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  in  1  fetch request.
- ireq_addr  in  ADDR_W  fetch address.
- ireq_ready  out  1  one-cycle pulse: fetch request captured.
- irsp_valid  out  1  one-cycle pulse: irsp_data valid.
- irsp_data  out  DATA_W  fetched word.
- dreq_valid  in  1  data request.
- dreq_write  in  1  1 = store, 0 = load.
- dreq_addr  in  ADDR_W  data address.
- dreq_wdata  in  DATA_W  store data.
- dreq_be  in  DATA_W/8  store/load byte enables.
- dreq_ready  out  1  one-cycle pulse: data request captured.
- drsp_valid  out  1  one-cycle pulse: load data valid (never for stores).
- drsp_data  out  DATA_W  load data.
- address  out  ADDR_W  bus address.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- writedata  out  DATA_W  bus write data.
- byteenable  out  DATA_W/8  bus byte enables.
- waitrequest  in  1  slave stall.
- readdata  in  DATA_W  slave read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset value of every output is 0; state = IDLE; last_grant = D, so I wins the first tie.
- Reset asserted mid-transfer abandons the transfer at once: strobes drop asynchronously and no response is issued.
- All bus outputs are registered.
- States: IDLE, ISSUE, WAIT_DATA.
- IDLE, no valid request: stay in IDLE, bus outputs at 0.
- IDLE, one or more valids: grant one requester.
  - Arbitration is round-robin: on a tie, grant the requester that is not last_grant.
  - Same cycle: pulse the winner's ready, capture its address/wdata/be/write into the bus registers, update last_grant, go to ISSUE.
  - Fetch is always a read with byteenable all ones.
  - Address is passed through unmodified; no alignment checks.
  - byteenable = 0 is still issued.
- ISSUE: exactly one of read/write is high.
  - Hold address, writedata, byteenable and strobe stable while waitrequest = 1, with no timeout.
  - Acceptance is the posedge with waitrequest = 0; the strobe drops on the next cycle.
  - Write accepted: go to IDLE; no response.
  - Read accepted, RD_LAT = 0: sample readdata at that same edge, pulse the owner's rsp_valid next cycle, go to IDLE.
  - Read accepted, RD_LAT ≥ 1: load counter = RD_LAT − 1, go to WAIT_DATA.
- WAIT_DATA: decrement the counter each cycle.
  - At counter 0, sample readdata into the owner's rsp_data, pulse rsp_valid for one cycle, go to IDLE.
  - rsp_data holds its value until the next response to that requester.
- Requester contract:
  - A requester keeps valid and its fields stable until it sees ready.
  - A request deasserted before ready is simply not served.
  - At most one outstanding transfer in total; new requests are not considered until the state returns to IDLE.
- Throughput: with RD_LAT = 1 and no stalls, a read takes 3 cycles from grant to IDLE; a write takes 2.
- A response pulse and a new grant may occur in the same cycle.

Decomposition:
- Package `bus_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT_DATA};
  - owner enum {OWN_I, OWN_D};
  - constant BE_ALL;
  - localparam RD_LAT maximum (3).
- One sub-module: `rr_arb2`, a combinational 2-way round-robin pick from {ireq_valid, dreq_valid, last_grant}, outputs a grant one-hot.
- The FSM, counter and registers stay in the top.

Test Plan:
- After reset, ireq_valid = 1, ireq_addr = 0xBFC00000, waitrequest = 0, RD_LAT = 1, slave returns 0x3C02FFFF → ireq_ready pulses cycle 0; read = 1 with address 0xBFC00000, byteenable 1111 in cycle 1; irsp_valid with 0x3C02FFFF in cycle 3.
- ireq and dreq (load 0x00001000) both valid continuously → grants alternate I, D, I, D; no requester is granted twice in a row while the other waits.
- Store dreq_addr = 0x10, wdata = 0xDEADBEEF, be = 0011, waitrequest high for 4 cycles → write, address and data held stable for 5 cycles; write drops after acceptance; drsp_valid never pulses.
- RD_LAT = 0 and RD_LAT = 3 builds, load returning 0xFFFF0000 → drsp_valid arrives 1 and 4 cycles after acceptance respectively, with correct data.
- Reset asserted while in ISSUE with waitrequest = 1 → read/write/busy drop to 0 immediately; after release, the first tie grants I; no stale response pulse.
- dreq_valid withdrawn before dreq_ready while I is being served → D is never issued; the bus returns to IDLE with busy = 0.
